// File: rtl/back1_vram_sequencer_if.sv
// CPU-side request/acknowledge bundle for the Back1 tile VRAM sequencer.
// master = CPU, slave = sequencer.
interface back1_vram_sequencer_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_wait
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_wait
    );
endinterface

// File: rtl/back1_vram_sequencer.sv
// Back1 background VRAM sequencer: 8-phase tile fetch timing plus a
// CPU access window in phases 4..7 with video always taking priority.
module back1_vram_sequencer #(
    parameter int ACC_CYC = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    pix_cen,
    input  logic                    hstart,
    input  logic                    hblank,
    back1_vram_sequencer_if.slave   cpu,
    output logic                    V_C,
    output logic                    VFLGn,
    output logic                    VLK,
    output logic                    LA,
    output logic                    BACK1_VRAM_CSn,
    output logic                    VWE,
    output logic                    VOE,
    output logic                    VRD,
    output logic [11:0]             VA,
    output logic [7:0]              VD_out,
    input  logic [7:0]              VD_in
);

    localparam int CW = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;
    localparam logic [CW-1:0] CNT_LD = CW'(ACC_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      ph;
    logic [2:0]      ph_nxt;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic            after_done;
    logic [7:0]      rdata_q;
    logic            start;
    logic            last;
    logic            acc;
    logic            vid_nxt;

    // The only legal start point is the pix_cen edge that moves ph 3->4.
    assign start   = pix_cen && !hstart && (ph == 3'd3);
    assign last    = (cnt == '0);
    assign acc     = (state == ACCESS);
    assign vid_nxt = !hblank && (ph_nxt[2:1] == 2'b00);

    always_comb begin
        ph_nxt = ph;
        if (pix_cen) begin
            ph_nxt = hstart ? 3'd0 : ph + 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cpu.cpu_req && !after_done) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!cpu.cpu_req) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            ph    <= 3'd0;
            VFLGn <= 1'b1;
            V_C   <= 1'b1;
            VLK   <= 1'b0;
            LA    <= 1'b0;
        end else begin
            ph    <= ph_nxt;
            VFLGn <= !vid_nxt;
            V_C   <= !vid_nxt || (state_nxt == ACCESS);
            VLK   <= pix_cen && (ph == 3'd1) && !hblank;
            LA    <= pix_cen && (ph == 3'd3) && !hblank;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            after_done <= 1'b0;
            VA         <= 12'h000;
            VD_out     <= 8'hFF;
            rdata_q    <= 8'h00;
        end else begin
            state      <= state_nxt;
            after_done <= (state == DONE);
            if (state == WAIT && state_nxt == ACCESS) begin
                VA     <= cpu.cpu_addr;
                VD_out <= cpu.cpu_wdata;
                we_q   <= cpu.cpu_we;
                cnt    <= CNT_LD;
            end else if (acc) begin
                if (last) begin
                    VD_out <= 8'hFF;
                    if (!we_q) begin
                        rdata_q <= VD_in;
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    // Write strobe releases one cycle early so address/data hold past VWE.
    assign BACK1_VRAM_CSn = !acc;
    assign VWE            = !(acc && we_q && !last);
    assign VOE            = !(acc && !we_q);
    assign VRD            = acc && we_q;

    assign cpu.cpu_ack   = (state == DONE);
    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_wait  = cpu.cpu_req && (state != DONE) && !RESET;

endmodule

// File: tb/tb_back1_vram_sequencer.sv
// Directed bench for back1_vram_sequencer: pix_cen every 4 clks,
// ACC_CYC=4, phase model kept alongside the DUT for positioning.
module tb_back1_vram_sequencer;

    localparam int ACC = 4;

    logic        clk = 1'b0;
    logic        RESET;
    logic        pix_cen;
    logic        hstart;
    logic        hblank;
    logic        V_C, VFLGn, VLK, LA;
    logic        BACK1_VRAM_CSn, VWE, VOE, VRD;
    logic [11:0] VA;
    logic [7:0]  VD_out;
    logic [7:0]  VD_in;

    back1_vram_sequencer_if cpu ();

    back1_vram_sequencer #(.ACC_CYC(ACC)) dut (
        .clk            (clk),
        .RESET          (RESET),
        .pix_cen        (pix_cen),
        .hstart         (hstart),
        .hblank         (hblank),
        .cpu            (cpu.slave),
        .V_C            (V_C),
        .VFLGn          (VFLGn),
        .VLK            (VLK),
        .LA             (LA),
        .BACK1_VRAM_CSn (BACK1_VRAM_CSn),
        .VWE            (VWE),
        .VOE            (VOE),
        .VRD            (VRD),
        .VA             (VA),
        .VD_out         (VD_out),
        .VD_in          (VD_in)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int         pc;
    logic [2:0] tb_ph;

    // capture results of run_access
    int         cs_n, cs_first_i, cs_pc, bus_bad, vwe_n, vwe_bad, voe_n;
    int         ack_n, ack_i0, ack_i1, vfl_n, vlk_n, vlk_i, la_n;
    logic [2:0] cs_ph;
    logic [7:0] ack_vd, ack_rd;
    logic       ack_wait, wait0;

    initial forever #5 clk = ~clk;

    // pix_cen generator and reference phase model
    initial begin
        pc      = 0;
        pix_cen = 1'b0;
        tb_ph   = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            if (RESET) tb_ph = 3'd0;
            else if (pix_cen) tb_ph = hstart ? 3'd0 : tb_ph + 3'd1;
            pc      = (pc + 1) % 4;
            pix_cen = (pc == 3);
        end
    end

    task automatic wait_ph(input logic [2:0] p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tb_ph == p && pc == 0) && n < 100);
        if (n >= 100) begin
            chk_cnt++;
            $display("FAIL wait_ph timeout: phase %0d never reached", p);
        end
    endtask

    task automatic do_hstart();
        int n = 0;
        while (pc != 3 && n < 8) begin
            @(negedge clk);
            n++;
        end
        hstart = 1'b1;
        @(negedge clk);
        hstart = 1'b0;
    endtask

    task automatic run_access(input logic we, input logic [11:0] a,
                              input logic [7:0] d, input int ncyc,
                              input bit drop);
        cpu.cpu_req   = 1'b1;
        cpu.cpu_we    = we;
        cpu.cpu_addr  = a;
        cpu.cpu_wdata = d;
        cs_n = 0; cs_first_i = -1; cs_pc = -1; cs_ph = 3'd0;
        bus_bad = 0; vwe_n = 0; vwe_bad = 0; voe_n = 0;
        ack_n = 0; ack_i0 = -1; ack_i1 = -1;
        vfl_n = 0; vlk_n = 0; vlk_i = -1; la_n = 0;
        ack_vd = 8'h00; ack_rd = 8'h00; ack_wait = 1'b1; wait0 = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) wait0 = cpu.cpu_wait;
            if (BACK1_VRAM_CSn === 1'b0) begin
                if (cs_n == 0) begin
                    cs_first_i = i; cs_ph = tb_ph; cs_pc = pc;
                end
                if (VA !== a || VD_out !== d || VRD !== we || V_C !== 1'b1)
                    bus_bad++;
                if (VWE === 1'b0 && (cs_n % ACC) >= ACC - 1) vwe_bad++;
                cs_n++;
            end else if (VWE === 1'b0 || VOE === 1'b0) begin
                vwe_bad++;
            end
            if (VWE === 1'b0) vwe_n++;
            if (VOE === 1'b0) voe_n++;
            if (VFLGn === 1'b0) vfl_n++;
            if (LA === 1'b1) la_n++;
            if (VLK === 1'b1) begin
                if (vlk_n == 0) vlk_i = i;
                vlk_n++;
            end
            if (cpu.cpu_ack === 1'b1) begin
                if (ack_n == 0) begin
                    ack_i0 = i; ack_vd = VD_out;
                    ack_rd = cpu.cpu_rdata; ack_wait = cpu.cpu_wait;
                end else begin
                    ack_i1 = i;
                end
                ack_n++;
                if (drop) cpu.cpu_req = 1'b0;
            end
        end
        cpu.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        hstart = 1'b0; hblank = 1'b0; VD_in = 8'h00;
        cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b0;
        cpu.cpu_addr = 12'h000; cpu.cpu_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({V_C, VFLGn, VLK, LA} !== 4'b1100)
            $display("FAIL rst_video: got %b want 1100", {V_C, VFLGn, VLK, LA});
        else pass_cnt++;
        chk_cnt++;
        if ({BACK1_VRAM_CSn, VWE, VOE, VRD} !== 4'b1110)
            $display("FAIL rst_bus: got %b want 1110",
                     {BACK1_VRAM_CSn, VWE, VOE, VRD});
        else pass_cnt++;
        chk_cnt++;
        if (VA !== 12'h000) $display("FAIL rst_va: got %h want 000", VA);
        else pass_cnt++;
        chk_cnt++;
        if (VD_out !== 8'hFF) $display("FAIL rst_vd: got %h want ff", VD_out);
        else pass_cnt++;
        chk_cnt++;
        if ({cpu.cpu_ack, cpu.cpu_wait} !== 2'b00)
            $display("FAIL rst_ack_wait: got %b want 00",
                     {cpu.cpu_ack, cpu.cpu_wait});
        else pass_cnt++;
        chk_cnt++;
        if (cpu.cpu_rdata !== 8'h00)
            $display("FAIL rst_rdata: got %h want 00", cpu.cpu_rdata);
        else pass_cnt++;
        cpu.cpu_req = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic test_video();
        int vfl_bad = 0, vc_bad = 0, nvlk = 0, la_cnt = 0;
        int vlk_a = -1, vlk_b = -1, la_a = -1;
        do_hstart();
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) @(negedge clk);
            if (VFLGn !== ((i % 32) >= 8)) vfl_bad++;
            if (V_C !== ((i % 32) >= 8)) vc_bad++;
            if (VLK === 1'b1) begin
                if (nvlk == 0) vlk_a = i; else vlk_b = i;
                nvlk++;
            end
            if (LA === 1'b1) begin
                if (la_cnt == 0) la_a = i;
                la_cnt++;
            end
        end
        chk_cnt++;
        if (vfl_bad != 0) $display("FAIL vid_vflgn: %0d bad clks, want 0", vfl_bad);
        else pass_cnt++;
        chk_cnt++;
        if (vc_bad != 0) $display("FAIL vid_vc: %0d bad clks, want 0", vc_bad);
        else pass_cnt++;
        chk_cnt++;
        if (nvlk != 2 || vlk_a != 8 || vlk_b != 40)
            $display("FAIL vid_vlk: n=%0d at %0d,%0d want 2 at 8,40",
                     nvlk, vlk_a, vlk_b);
        else pass_cnt++;
        chk_cnt++;
        if (la_cnt != 1 || la_a != 16)
            $display("FAIL vid_la: n=%0d at %0d want 1 at 16", la_cnt, la_a);
        else pass_cnt++;
    endtask

    task automatic test_write();
        wait_ph(3'd1);
        run_access(1'b1, 12'h123, 8'hA5, 24, 1'b1);
        chk_cnt++;
        if (wait0 !== 1'b1) $display("FAIL wr_wait: got %b want 1", wait0);
        else pass_cnt++;
        chk_cnt++;
        if (cs_n != 4) $display("FAIL wr_cs_len: got %0d want 4", cs_n);
        else pass_cnt++;
        chk_cnt++;
        if (cs_ph !== 3'd4 || cs_pc != 0 || cs_first_i != 11)
            $display("FAIL wr_cs_start: ph %0d pc %0d i %0d want 4 0 11",
                     cs_ph, cs_pc, cs_first_i);
        else pass_cnt++;
        chk_cnt++;
        if (bus_bad != 0) $display("FAIL wr_bus: %0d bad clks want 0", bus_bad);
        else pass_cnt++;
        chk_cnt++;
        if (vwe_n != 3 || vwe_bad != 0)
            $display("FAIL wr_vwe: low %0d bad %0d want 3 0", vwe_n, vwe_bad);
        else pass_cnt++;
        chk_cnt++;
        if (voe_n != 0) $display("FAIL wr_voe: low %0d want 0", voe_n);
        else pass_cnt++;
        chk_cnt++;
        if (ack_n != 1 || ack_i0 != 15)
            $display("FAIL wr_ack: n=%0d at %0d want 1 at 15", ack_n, ack_i0);
        else pass_cnt++;
        chk_cnt++;
        if (ack_vd !== 8'hFF) $display("FAIL wr_vd_done: got %h want ff", ack_vd);
        else pass_cnt++;
    endtask

    task automatic test_read();
        VD_in = 8'h3C;
        wait_ph(3'd1);
        run_access(1'b0, 12'h0FF, 8'h00, 24, 1'b1);
        VD_in = 8'h00;
        chk_cnt++;
        if (voe_n != 4 || vwe_n != 0 || vwe_bad != 0)
            $display("FAIL rd_strobes: voe %0d vwe %0d bad %0d want 4 0 0",
                     voe_n, vwe_n, vwe_bad);
        else pass_cnt++;
        chk_cnt++;
        if (bus_bad != 0 || cs_n != 4)
            $display("FAIL rd_bus: bad %0d cs %0d want 0 4", bus_bad, cs_n);
        else pass_cnt++;
        chk_cnt++;
        if (ack_n != 1 || ack_rd !== 8'h3C)
            $display("FAIL rd_data: n=%0d rdata %h want 1 3c", ack_n, ack_rd);
        else pass_cnt++;
        chk_cnt++;
        if (ack_wait !== 1'b0) $display("FAIL rd_wait_ack: got %b want 0", ack_wait);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (cpu.cpu_rdata !== 8'h3C)
            $display("FAIL rd_hold: got %h want 3c", cpu.cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_hblank();
        hblank = 1'b1;
        wait_ph(3'd1);
        run_access(1'b1, 12'h456, 8'h5A, 24, 1'b1);
        hblank = 1'b0;
        chk_cnt++;
        if (vfl_n != 0 || vlk_n != 0 || la_n != 0)
            $display("FAIL hb_video: vflgn %0d vlk %0d la %0d want 0 0 0",
                     vfl_n, vlk_n, la_n);
        else pass_cnt++;
        chk_cnt++;
        if (cs_ph !== 3'd4 || cs_pc != 0 || cs_n != 4 || bus_bad != 0)
            $display("FAIL hb_access: ph %0d pc %0d cs %0d bad %0d want 4 0 4 0",
                     cs_ph, cs_pc, cs_n, bus_bad);
        else pass_cnt++;
        chk_cnt++;
        if (ack_n != 1) $display("FAIL hb_ack: got %0d want 1", ack_n);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wait_ph(3'd1);
        run_access(1'b1, 12'hABC, 8'h11, 56, 1'b0);
        chk_cnt++;
        if (ack_n != 2 || cs_n != 8)
            $display("FAIL b2b_count: ack %0d cs %0d want 2 8", ack_n, cs_n);
        else pass_cnt++;
        chk_cnt++;
        if (ack_i0 != 15 || ack_i1 != 47)
            $display("FAIL b2b_spacing: acks at %0d,%0d want 15,47",
                     ack_i0, ack_i1);
        else pass_cnt++;
    endtask

    task automatic test_hstart_ph5();
        wait_ph(3'd5);
        cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b1;
        cpu.cpu_addr = 12'h789; cpu.cpu_wdata = 8'hC3;
        do_hstart();
        chk_cnt++;
        if (VFLGn !== 1'b0 || tb_ph != 3'd0)
            $display("FAIL hs_realign: vflgn %b ph %0d want 0 0", VFLGn, tb_ph);
        else pass_cnt++;
        run_access(1'b1, 12'h789, 8'hC3, 30, 1'b1);
        chk_cnt++;
        if (vlk_i != 7) $display("FAIL hs_vlk: at %0d want 7", vlk_i);
        else pass_cnt++;
        chk_cnt++;
        if (cs_first_i != 15 || ack_i0 != 19 || ack_n != 1)
            $display("FAIL hs_access: cs %0d ack %0d n %0d want 15 19 1",
                     cs_first_i, ack_i0, ack_n);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen = 0, pre_ack = 0;
        wait_ph(3'd1);
        cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b1;
        cpu.cpu_addr = 12'h3AB; cpu.cpu_wdata = 8'h77;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu.cpu_ack === 1'b1) pre_ack++;
            if (BACK1_VRAM_CSn === 1'b0) seen++;
            if (seen == 2) break;
        end
        chk_cnt++;
        if (seen != 2) $display("FAIL rm_reach: cs clks %0d want 2", seen);
        else pass_cnt++;
        RESET = 1'b1;
        #1;
        chk_cnt++;
        if ({BACK1_VRAM_CSn, VWE, VOE} !== 3'b111 || VA !== 12'h000)
            $display("FAIL rm_immediate: csn/vwe/voe %b va %h want 111 000",
                     {BACK1_VRAM_CSn, VWE, VOE}, VA);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (cpu.cpu_ack !== 1'b0 || pre_ack != 0 || BACK1_VRAM_CSn !== 1'b1)
            $display("FAIL rm_no_ack: ack %b pre %0d csn %b want 0 0 1",
                     cpu.cpu_ack, pre_ack, BACK1_VRAM_CSn);
        else pass_cnt++;
        RESET = 1'b0;
        run_access(1'b1, 12'h3AB, 8'h77, 40, 1'b1);
        chk_cnt++;
        if (cs_ph !== 3'd4 || cs_pc != 0 || cs_n != 4 || ack_n != 1 ||
            ack_i0 - cs_first_i != 4)
            $display("FAIL rm_retry: ph %0d pc %0d cs %0d ack %0d lat %0d want 4 0 4 1 4",
                     cs_ph, cs_pc, cs_n, ack_n, ack_i0 - cs_first_i);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_video();
        test_write();
        test_read();
        test_hblank();
        test_back_to_back();
        test_hstart_ph5();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
